// File: rtl/layer_pkg.sv
// Shared types and constants for the layer mixer: fade FSM states, the sync
// bundle that travels with each pixel, and the channel brightness scaler.
package layer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2
   } fade_state_t;

   localparam logic [4:0]  LEVEL_MAX               = 5'd16;
   localparam logic [11:0] TRANSPARENT_KEY_DEFAULT = 12'hF0F;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_t;

   localparam sync_t SYNC_RESET = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

   // Brightness scale: (c * level) >> 4 on a 9-bit product, kept to 4 bits.
   function automatic logic [3:0] scale_channel(input logic [3:0] c, input logic [4:0] level);
      return 4'(({5'd0, c} * {4'd0, level}) >> 4);
   endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with a reset pattern; also exposes one bit taken
// a single stage before the output so callers can act one cycle early.
module delay_line #(
   parameter int               WIDTH       = 3,
   parameter int               DEPTH       = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               TAP_BIT     = 0
) (
   input  logic             pixel_clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] delayed,
   output logic             tap_bit
);

   logic [DEPTH-1:0][WIDTH-1:0] stages;

   // NOTE: every stage gets the reset pattern, so no stale sync from before
   // reset can ever reach the output; non-blocking assignments keep the
   // shift order independent of statement order.
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         stages <= {DEPTH{RESET_VALUE}};
      end else begin
         stages[0] <= data;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign delayed = stages[DEPTH-1];

   generate
      if (DEPTH > 1) begin : g_tap_stage
         assign tap_bit = stages[DEPTH-2][TAP_BIT];
      end else begin : g_tap_input
         assign tap_bit = data[TAP_BIT];
      end
   endgenerate

endmodule

// File: rtl/layer_mixer.sv
// Two-layer pixel mixer: sprite-over-background keying, frame-stepped global
// fade, one output register stage, syncs delayed to match the colour path.
module layer_mixer
   import layer_pkg::*;
#(
   parameter int          LAYER_LATENCY   = 2,
   parameter logic [11:0] TRANSPARENT_KEY = TRANSPARENT_KEY_DEFAULT
) (
   input  logic        pixel_clk,
   input  logic        reset_n,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        de_in,
   input  logic [11:0] bg_color,
   input  logic [11:0] fg_color,
   input  logic        fg_valid,
   input  logic        fade_req,
   input  logic        fade_dir,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        hs_out,
   output logic        vs_out,
   output logic        de_out,
   output logic        fade_busy
);

   sync_t sync_in, sync_out;
   logic  de_aligned;

   assign sync_in = '{hs: hs_in, vs: vs_in, de: de_in};

   // de is bit 0 of sync_t; its early tap lines up with bg_color/fg_color.
   delay_line #(
      .WIDTH       (3),
      .DEPTH       (LAYER_LATENCY + 1),
      .RESET_VALUE (SYNC_RESET),
      .TAP_BIT     (0)
   ) u_sync_delay (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .data      (sync_in),
      .delayed   (sync_out),
      .tap_bit   (de_aligned)
   );

   assign hs_out = sync_out.hs;
   assign vs_out = sync_out.vs;
   assign de_out = sync_out.de;

   // Frame tick: rising edge of the registered vsync, i.e. end of sync pulse.
   logic vs_q, vs_q2, frame_tick;

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q  <= 1'b1;
         vs_q2 <= 1'b1;
      end else begin
         vs_q  <= vs_in;
         vs_q2 <= vs_q;
      end
   end

   assign frame_tick = vs_q & ~vs_q2;

   fade_state_t state, state_next;
   logic [4:0]  level, level_next;

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         level <= LEVEL_MAX;
      end else begin
         state <= state_next;
         level <= level_next;
      end
   end

   // NOTE: hold-value defaults up front keep this block free of latches.
   always_comb begin
      state_next = state;
      level_next = level;
      case (state)
         IDLE: begin
            if (fade_req) state_next = fade_dir ? FADE_IN : FADE_OUT;
         end
         FADE_OUT: begin
            if (level == 5'd0) begin
               state_next = IDLE;
            end else if (frame_tick) begin
               level_next = level - 5'd1;
               if (level == 5'd1) state_next = IDLE;
            end
         end
         FADE_IN: begin
            if (level == LEVEL_MAX) begin
               state_next = IDLE;
            end else if (frame_tick) begin
               level_next = level + 5'd1;
               if (level == LEVEL_MAX - 5'd1) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fade_busy = (state != IDLE);
   end

   logic [11:0] selected;

   always_comb begin
      selected = (fg_valid && (fg_color != TRANSPARENT_KEY)) ? fg_color : bg_color;
   end

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         red   <= 4'd0;
         green <= 4'd0;
         blue  <= 4'd0;
      end else if (de_aligned) begin
         red   <= scale_channel(selected[11:8], level);
         green <= scale_channel(selected[7:4],  level);
         blue  <= scale_channel(selected[3:0],  level);
      end else begin
         red   <= 4'd0;
         green <= 4'd0;
         blue  <= 4'd0;
      end
   end

endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer: keying, blanking, sync alignment, fades,
// request lock-out, mid-fade reset and fade_req/frame-tick collision.
module tb_layer_mixer;

   logic        pixel_clk = 1'b0;
   logic        reset_n;
   logic        hs_in, vs_in, de_in;
   logic [11:0] bg_color, fg_color;
   logic        fg_valid, fade_req, fade_dir;
   logic [3:0]  red, green, blue;
   logic        hs_out, vs_out, de_out, fade_busy;

   int checks = 0;
   int errors = 0;

   always #5 pixel_clk = ~pixel_clk;

   layer_mixer #(.LAYER_LATENCY(2), .TRANSPARENT_KEY(12'hF0F)) dut (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .hs_in     (hs_in),
      .vs_in     (vs_in),
      .de_in     (de_in),
      .bg_color  (bg_color),
      .fg_color  (fg_color),
      .fg_valid  (fg_valid),
      .fade_req  (fade_req),
      .fade_dir  (fade_dir),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .hs_out    (hs_out),
      .vs_out    (vs_out),
      .de_out    (de_out),
      .fade_busy (fade_busy)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge pixel_clk);
         #1;
      end
   endtask

   // Vsync low for two cycles, then high; the level moves one cycle after the
   // rise and the colour register shows it one cycle later.
   task automatic pulse_vsync();
      vs_in = 1'b0;
      step(2);
      vs_in = 1'b1;
      step(3);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step(3);
      checks++;
      if ({red, green, blue} !== 12'h000) begin
         errors++; $display("FAIL reset_rgb: got %h expected %h", {red, green, blue}, 12'h000);
      end
      checks++;
      if ({hs_out, vs_out, de_out} !== 3'b110) begin
         errors++; $display("FAIL reset_syncs: got %b expected %b", {hs_out, vs_out, de_out}, 3'b110);
      end
      checks++;
      if (fade_busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b expected %b", fade_busy, 1'b0);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_passthrough();
      bg_color = 12'h000;
      fg_valid = 1'b0;
      de_in    = 1'b1;
      step(2);
      checks++;
      if (de_out !== 1'b0) begin
         errors++; $display("FAIL de_out_early: got %b expected %b", de_out, 1'b0);
      end
      step(1);
      checks++;
      if (de_out !== 1'b1) begin
         errors++; $display("FAIL de_out_aligned: got %b expected %b", de_out, 1'b1);
      end
      bg_color = 12'h4A8;
      step(1);
      checks++;
      if ({red, green, blue} !== 12'h4A8) begin
         errors++; $display("FAIL passthrough_bg: got %h expected %h", {red, green, blue}, 12'h4A8);
      end
   endtask

   task automatic test_foreground();
      logic [11:0] fg_vec [4] = '{12'hC31, 12'hF0F, 12'hF0E, 12'hC31};
      logic        val_vec[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [11:0] exp_vec[4] = '{12'hC31, 12'h4A8, 12'hF0E, 12'h4A8};
      for (int i = 0; i < 4; i++) begin
         fg_color = fg_vec[i];
         fg_valid = val_vec[i];
         step(1);
         checks++;
         if ({red, green, blue} !== exp_vec[i]) begin
            errors++;
            $display("FAIL fg_select[%0d]: got %h expected %h", i, {red, green, blue}, exp_vec[i]);
         end
      end
   endtask

   task automatic test_de_blank();
      fg_valid = 1'b0;
      bg_color = 12'hFFF;
      step(1);
      de_in = 1'b0;
      step(2);
      checks++;
      if ({red, green, blue, de_out} !== {12'hFFF, 1'b1}) begin
         errors++; $display("FAIL blank_before: got %h/%b expected fff/1", {red, green, blue}, de_out);
      end
      step(1);
      checks++;
      if ({red, green, blue, de_out} !== {12'h000, 1'b0}) begin
         errors++; $display("FAIL blank_aligned: got %h/%b expected 000/0", {red, green, blue}, de_out);
      end
      de_in = 1'b1;
      step(3);
      checks++;
      if ({red, green, blue, de_out} !== {12'hFFF, 1'b1}) begin
         errors++; $display("FAIL blank_restore: got %h/%b expected fff/1", {red, green, blue}, de_out);
      end
   endtask

   task automatic test_fade_out();
      fade_req = 1'b1; fade_dir = 1'b0;
      step(1);
      fade_req = 1'b0;
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b1, 12'hFFF}) begin
         errors++; $display("FAIL fade_out_start: got %b/%h expected 1/fff", fade_busy, {red, green, blue});
      end
      repeat (8) pulse_vsync();
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b1, 12'h777}) begin
         errors++; $display("FAIL fade_out_8: got %b/%h expected 1/777", fade_busy, {red, green, blue});
      end
      repeat (7) pulse_vsync();
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b1, 12'h000}) begin
         errors++; $display("FAIL fade_out_15: got %b/%h expected 1/000", fade_busy, {red, green, blue});
      end
      pulse_vsync();
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b0, 12'h000}) begin
         errors++; $display("FAIL fade_out_16: got %b/%h expected 0/000", fade_busy, {red, green, blue});
      end
   endtask

   // Level is 0 on entry: zero-tick fade-out, full fade-in, zero-tick fade-in.
   task automatic test_fade_in_and_zero_tick();
      fade_req = 1'b1; fade_dir = 1'b0;
      step(1);
      fade_req = 1'b0;
      checks++;
      if (fade_busy !== 1'b1) begin
         errors++; $display("FAIL zero_out_entry: got %b expected %b", fade_busy, 1'b1);
      end
      step(1);
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b0, 12'h000}) begin
         errors++; $display("FAIL zero_out_exit: got %b/%h expected 0/000", fade_busy, {red, green, blue});
      end
      fade_req = 1'b1; fade_dir = 1'b1;
      step(1);
      fade_req = 1'b0;
      repeat (8) pulse_vsync();
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b1, 12'h777}) begin
         errors++; $display("FAIL fade_in_8: got %b/%h expected 1/777", fade_busy, {red, green, blue});
      end
      repeat (8) pulse_vsync();
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b0, 12'hFFF}) begin
         errors++; $display("FAIL fade_in_16: got %b/%h expected 0/fff", fade_busy, {red, green, blue});
      end
      fade_req = 1'b1; fade_dir = 1'b1;
      step(1);
      fade_req = 1'b0;
      checks++;
      if (fade_busy !== 1'b1) begin
         errors++; $display("FAIL zero_in_entry: got %b expected %b", fade_busy, 1'b1);
      end
      step(1);
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b0, 12'hFFF}) begin
         errors++; $display("FAIL zero_in_exit: got %b/%h expected 0/fff", fade_busy, {red, green, blue});
      end
   endtask

   task automatic test_ignore_and_reset();
      fade_req = 1'b1; fade_dir = 1'b0;
      step(1);
      fade_req = 1'b0;
      repeat (6) pulse_vsync();
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b1, 12'h999}) begin
         errors++; $display("FAIL level10: got %b/%h expected 1/999", fade_busy, {red, green, blue});
      end
      fade_req = 1'b1; fade_dir = 1'b1;
      step(1);
      fade_req = 1'b0; fade_dir = 1'b0;
      pulse_vsync();
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b1, 12'h888}) begin
         errors++; $display("FAIL req_ignored: got %b/%h expected 1/888", fade_busy, {red, green, blue});
      end
      hs_in = 1'b0; vs_in = 1'b0;
      step(3);
      checks++;
      if ({hs_out, vs_out} !== 2'b00) begin
         errors++; $display("FAIL syncs_low: got %b expected %b", {hs_out, vs_out}, 2'b00);
      end
      reset_n = 1'b0;
      #2;
      checks++;
      if ({red, green, blue} !== 12'h000) begin
         errors++; $display("FAIL midfade_reset_rgb: got %h expected %h", {red, green, blue}, 12'h000);
      end
      checks++;
      if ({hs_out, vs_out, de_out, fade_busy} !== 4'b1100) begin
         errors++;
         $display("FAIL midfade_reset_ctl: got %b expected %b", {hs_out, vs_out, de_out, fade_busy}, 4'b1100);
      end
      hs_in = 1'b1; vs_in = 1'b1;
      reset_n = 1'b1;
      step(3);
      checks++;
      if ({fade_busy, de_out, red, green, blue} !== {2'b01, 12'hFFF}) begin
         errors++;
         $display("FAIL post_reset_level: got %b/%b/%h expected 0/1/fff", fade_busy, de_out, {red, green, blue});
      end
   endtask

   task automatic test_tick_collision();
      vs_in = 1'b0;
      step(2);
      vs_in = 1'b1;
      step(1);
      fade_req = 1'b1; fade_dir = 1'b0;
      step(1);
      fade_req = 1'b0;
      checks++;
      if (fade_busy !== 1'b1) begin
         errors++; $display("FAIL collide_busy: got %b expected %b", fade_busy, 1'b1);
      end
      step(4);
      checks++;
      if ({red, green, blue} !== 12'hFFF) begin
         errors++; $display("FAIL collide_hold: got %h expected %h", {red, green, blue}, 12'hFFF);
      end
      pulse_vsync();
      checks++;
      if ({fade_busy, red, green, blue} !== {1'b1, 12'hEEE}) begin
         errors++; $display("FAIL collide_first_dec: got %b/%h expected 1/eee", fade_busy, {red, green, blue});
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      hs_in    = 1'b1;
      vs_in    = 1'b1;
      de_in    = 1'b0;
      bg_color = 12'h000;
      fg_color = 12'h000;
      fg_valid = 1'b0;
      fade_req = 1'b0;
      fade_dir = 1'b0;
      test_reset();
      test_passthrough();
      test_foreground();
      test_de_blank();
      test_fade_out();
      test_fade_in_and_zero_tick();
      test_ignore_and_reset();
      test_tick_collision();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/layer_mixer.md
LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 SHALL have parameter LAYER_LATENCY, default 2, meaning pixel_clk cycles from DrawX/DrawY to a valid layer color.
REQ-002 SHALL have parameter TRANSPARENT_KEY, default 12'hF0F, meaning the foreground color treated as transparent.
REQ-003 SHALL have port pixel_clk  input  1  meaning the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port hs_in, vs_in  input  1 each  meaning active-low syncs aligned with DrawX/DrawY.
REQ-006 SHALL have port de_in  input  1  meaning display enable (1 = visible), aligned with DrawX/DrawY.
REQ-007 SHALL have port bg_color  input  12  meaning the background layer color (RGB444), LAYER_LATENCY cycles behind DrawX/DrawY.
REQ-008 SHALL have port fg_color  input  12  meaning the sprite layer color, same alignment as bg_color.
REQ-009 SHALL have port fg_valid  input  1  meaning the sprite layer covers this pixel, same alignment as bg_color.
REQ-010 SHALL have port fade_req  input  1  meaning a single-cycle fade start pulse.
REQ-011 SHALL have port fade_dir  input  1  meaning fade direction (0 = fade out, 1 = fade in), sampled with fade_req.
REQ-012 SHALL have port red, green, blue  output  4 each  meaning the final pixel channels.
REQ-013 SHALL have port hs_out, vs_out, de_out  output  1 each  meaning the syncs and enable aligned with red/green/blue.
REQ-014 SHALL have port fade_busy  output  1  meaning high when the FSM is not in IDLE.

Function
REQ-015 SHALL delay hs_in, vs_in and de_in by exactly LAYER_LATENCY+1 cycles to produce hs_out, vs_out and de_out.
REQ-016 SHALL select fg_color when fg_valid=1 and fg_color!=TRANSPARENT_KEY, and bg_color otherwise.
REQ-017 SHALL scale each channel of the selected color as out = (c * level) >> 4, where level is an unsigned 5-bit value in 0..16 and the 9-bit product is truncated to 4 bits.
REQ-018 SHALL register red, green and blue once, so color output latency is 1 cycle after bg_color/fg_color.
REQ-019 SHALL force red, green and blue to 0 in any cycle where de_in delayed by LAYER_LATENCY is 0.
REQ-020 SHALL define a frame tick as a 0->1 transition of the registered vs_in, i.e. sync pulse end.
REQ-021 SHALL implement FSM states IDLE, FADE_OUT and FADE_IN.
REQ-022 SHALL, in IDLE, on fade_req=1 with fade_dir=0, go to FADE_OUT on the next cycle; with fade_dir=1, go to FADE_IN.
REQ-023 SHALL, in FADE_OUT, decrement level by 1 per frame tick, and return to IDLE in the same cycle level becomes 0.
REQ-024 SHALL, in FADE_IN, increment level by 1 per frame tick, and return to IDLE in the same cycle level becomes 16.
REQ-025 SHALL complete in zero ticks when a fade starts at its target level (FADE_OUT at 0, FADE_IN at 16), returning to IDLE the cycle after entry.
REQ-026 SHALL ignore fade_req while fade_busy=1.
REQ-027 SHALL change level only on frame ticks, so level is constant within a frame.
REQ-028 SHALL give priority to fade_req when fade_req and a frame tick coincide in IDLE: enter the fade state, and level is unchanged that cycle.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously clear all color outputs to 0.
REQ-030 SHALL, while reset_n=0, set hs_out=1, vs_out=1 and de_out=0, and set every delay-line stage to those values.
REQ-031 SHALL, while reset_n=0, set the FSM to IDLE, level to 16 and fade_busy to 0.
REQ-032 SHALL abort any fade in progress when reset is asserted mid-fade, with no residual state.

Structure
REQ-033 SHALL place fade_state_t (IDLE, FADE_OUT, FADE_IN), LEVEL_MAX=16 and TRANSPARENT_KEY_DEFAULT=12'hF0F in shared package layer_pkg.
REQ-034 SHALL implement the sync/enable delay in one sub-module, delay_line, parameterised by width (3) and depth (LAYER_LATENCY+1), with reset value 3'b110 ({hs,vs,de}).

Verification
REQ-035 SHALL cover: reset release, then de_in=1, bg_color=12'h4A8, fg_valid=0 -> red/green/blue = 4/A/8 at 1 cycle after input; de_out asserted LAYER_LATENCY+1 cycles after de_in.
REQ-036 SHALL cover: fg_valid=1, fg_color=12'hC31 -> output C/3/1; then fg_color=12'hF0F -> output equals bg_color.
REQ-037 SHALL cover: de_in=0 with bg_color=12'hFFF -> output 0/0/0 at the aligned cycle.
REQ-038 SHALL cover: fade_req with fade_dir=0 at level 16 -> fade_busy=1; after 8 frame ticks bg 12'hFFF outputs 7/7/7; after 16 ticks 0/0/0 and fade_busy=0.
REQ-039 SHALL cover: during FADE_OUT at level 10, fade_req with fade_dir=1 -> ignored; then reset_n low mid-fade -> level 16, IDLE, outputs 0, hs_out/vs_out=1.
REQ-040 SHALL cover: fade_req coincident with a frame tick in IDLE -> level holds 16 that cycle, first decrement at the next tick.
